// File: rtl/imm_encoder.sv
// Iterative ARM data-processing immediate encoder: finds imm8/rot such that
// ROR(imm8, 2*rot) equals the constant (or its inverse), testing one rotation per clock.
module imm_encoder #(
    parameter bit ENABLE_INV = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_imm8,
    output logic [3:0]  out_rot,
    output logic        out_ok,
    output logic        out_inv
);

    typedef enum logic [1:0] {StIdle, StSearch, StSearchInv, StDone} state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_k, w_k_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_miss, w_miss_nxt;
    logic [7:0]  r_imm8, w_imm8_nxt;
    logic [3:0]  r_rot, w_rot_nxt;
    logic        r_ok, w_ok_nxt;
    logic        r_inv, w_inv_nxt;

    logic [31:0] w_src;
    logic [4:0]  w_amt;
    logic [63:0] w_dbl;
    logic [31:0] w_t;
    logic        w_match;

    // Rotating left by 2k undoes the decode-side rotate right; a match leaves only imm8.
    assign w_src   = (r_state == StSearchInv) ? ~r_data : r_data;
    assign w_amt   = {r_k, 1'b0};
    assign w_dbl   = {w_src, w_src} << w_amt;
    assign w_t     = w_dbl[63:32];
    assign w_match = (w_t[31:8] == 24'd0);

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign out_imm8  = r_imm8;
    assign out_rot   = r_rot;
    assign out_ok    = r_ok;
    assign out_inv   = r_inv;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_data_nxt  = r_data;
        w_miss_nxt  = r_miss;
        w_imm8_nxt  = r_imm8;
        w_rot_nxt   = r_rot;
        w_ok_nxt    = r_ok;
        w_inv_nxt   = r_inv;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_data_nxt  = in_data;
                    w_k_nxt     = 4'd0;
                    w_miss_nxt  = 1'b0;
                    w_state_nxt = StSearch;
                end
            end
            StSearch, StSearchInv: begin
                // A final miss takes one extra cycle to publish the unencodable result.
                if (r_miss) begin
                    w_imm8_nxt  = 8'd0;
                    w_rot_nxt   = 4'd0;
                    w_ok_nxt    = 1'b0;
                    w_inv_nxt   = 1'b0;
                    w_state_nxt = StDone;
                end else if (w_match) begin
                    w_imm8_nxt  = w_t[7:0];
                    w_rot_nxt   = r_k;
                    w_ok_nxt    = 1'b1;
                    w_inv_nxt   = (r_state == StSearchInv);
                    w_state_nxt = StDone;
                end else if (r_k == 4'd15) begin
                    if (ENABLE_INV && (r_state == StSearch)) begin
                        w_k_nxt     = 4'd0;
                        w_state_nxt = StSearchInv;
                    end else begin
                        w_miss_nxt = 1'b1;
                    end
                end else begin
                    w_k_nxt = r_k + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_k     <= 4'd0;
            r_data  <= 32'd0;
            r_miss  <= 1'b0;
            r_imm8  <= 8'd0;
            r_rot   <= 4'd0;
            r_ok    <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_data  <= w_data_nxt;
            r_miss  <= w_miss_nxt;
            r_imm8  <= w_imm8_nxt;
            r_rot   <= w_rot_nxt;
            r_ok    <= w_ok_nxt;
            r_inv   <= w_inv_nxt;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: one instance with inverted search, one without.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_valid0;
    logic        out_ready, out_ready0;
    logic [31:0] in_data;

    logic        in_ready, out_valid, out_ok, out_inv;
    logic [7:0]  out_imm8;
    logic [3:0]  out_rot;
    logic        in_ready0, out_valid0, out_ok0, out_inv0;
    logic [7:0]  out_imm80;
    logic [3:0]  out_rot0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_encoder #(.ENABLE_INV(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm8(out_imm8), .out_rot(out_rot), .out_ok(out_ok), .out_inv(out_inv)
    );

    imm_encoder #(.ENABLE_INV(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_imm8(out_imm80), .out_rot(out_rot0), .out_ok(out_ok0), .out_inv(out_inv0)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
        end
    endtask

    // Accept one constant, measure edges from acceptance to out_valid, check the result.
    task automatic run(input string name, input bit sel, input logic [31:0] data,
                       input int exp_lat, input logic [7:0] e_imm, input logic [3:0] e_rot,
                       input logic e_ok, input logic e_inv, input bit fields,
                       input bit release_out);
        int lat;
        @(negedge clk);
        check({name, " in_ready idle"}, sel ? in_ready0 : in_ready, 1);
        in_data = data;
        if (sel) in_valid0 = 1'b1;
        else in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        in_data   = ~data;
        check({name, " in_ready busy"}, sel ? in_ready0 : in_ready, 0);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if ((sel ? out_valid0 : out_valid) === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " ok"}, sel ? out_ok0 : out_ok, e_ok);
        check({name, " inv"}, sel ? out_inv0 : out_inv, e_inv);
        if (fields) begin
            check({name, " imm8"}, sel ? out_imm80 : out_imm8, e_imm);
            check({name, " rot"}, sel ? out_rot0 : out_rot, e_rot);
        end
        if (release_out) begin
            check({name, " in_ready in done"}, sel ? in_ready0 : in_ready, 0);
            @(posedge clk);
            #1;
            check({name, " valid after hs"}, sel ? out_valid0 : out_valid, 0);
            check({name, " in_ready after hs"}, sel ? in_ready0 : in_ready, 1);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_valid0  = 1'b0;
        out_ready  = 1'b1;
        out_ready0 = 1'b1;
        in_data    = 32'd0;
        #12;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst fields", {out_imm8, out_rot, out_ok, out_inv}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run("ff",       1'b0, 32'h0000_00FF, 1,  8'hFF, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1);
        run("ff000000", 1'b0, 32'hFF00_0000, 5,  8'hFF, 4'd4,  1'b1, 1'b0, 1'b1, 1'b1);
        run("104",      1'b0, 32'h0000_0104, 16, 8'h41, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
        run("inv",      1'b0, 32'hFFFF_FF00, 17, 8'hFF, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1);
        run("noinv",    1'b1, 32'hFFFF_FF00, 17, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        run("101",      1'b0, 32'h0000_0101, 33, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1);
        run("zero",     1'b0, 32'h0000_0000, 1,  8'h00, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1);

        // Backpressure: result must hold and new requests must be refused.
        out_ready = 1'b0;
        run("bp", 1'b0, 32'hAB00_0000, 5, 8'hAB, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h0000_00FF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp fields", {out_imm8, out_rot, out_ok, out_inv}, {8'hAB, 4'd4, 1'b1, 1'b0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp valid after hs", out_valid, 0);
        check("bp in_ready after hs", in_ready, 1);
        @(posedge clk);
        #1;
        check("bp no accept", out_valid, 0);
        check("bp still idle", in_ready, 1);

        // Asynchronous reset in the middle of a search at k=7.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000_0104;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid rst in_ready", in_ready, 1);
        check("mid rst out_valid", out_valid, 0);
        check("mid rst fields", {out_imm8, out_rot, out_ok, out_inv}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("post rst no valid", out_valid, 0);
        end
        run("after rst", 1'b0, 32'h0000_00FF, 1, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
